// File: rtl/mtd_pkg.sv
// Shared definitions for the MTD engine sequencer: FSM encoding and the
// bit positions of the engine's status pins.
package mtd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST     = 3'd1,
    ARM     = 3'd2,
    COLLECT = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int HB    = 1;
  localparam int EMPTY = 0;

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser for W independent asynchronous level inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: flops are written only with <= so every flop samples the pre-edge
  // value of its source; a blocking = here would collapse the two stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector; the
// one-cycle pulse appears three clk edges after the input rises.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic s;
  logic s_d;

  sync_2ff #(.W(1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_d   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s_d   <= s;
      pulse <= s & ~s_d;
    end
  end

endmodule

// File: rtl/mtd_ctrl.sv
// Sweep sequencer for the external MTD engine: reset it, wait for a sync
// period, wait for a ready block, then drain it word by word into the buffer.
module mtd_ctrl
  import mtd_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int RD_LAT     = 2,
  parameter int BLOCK_LEN  = 1024,
  parameter int TIMEOUT    = 65535,
  parameter int AW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          synclk,
  input  logic          err_clr,
  input  logic [1:0]    extern_mtd_state,
  input  logic [15:0]   extern_mtd_data,
  output logic          extern_mtd_en,
  output logic          extern_mtd_rst,
  output logic          mtd_wen,
  output logic [15:0]   mtd_wdata,
  output logic [AW-1:0] mtd_waddr,
  output logic          mtd_done,
  output logic          err_timeout,
  output logic          err_overrun,
  output logic          busy
);

  localparam int TMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(RD_LAT + 4);
  localparam int CW   = AW + 1;

  state_e          state, state_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [PW-1:0]   ph, ph_n;
  logic [CW-1:0]   wcnt, wcnt_n;
  logic            sync_p;
  logic            sync_pend, sync_pend_n;
  logic [1:0]      st_s;
  logic            hb, empty;
  logic            capture;
  logic            set_timeout;
  logic            set_overrun;
  logic            arm_entry;

  sync_edge u_sync_edge (
    .clk  (clk),
    .reset(reset),
    .d    (synclk),
    .pulse(sync_p)
  );

  sync_2ff #(.W(2)) u_sync_state (
    .clk  (clk),
    .reset(reset),
    .d    (extern_mtd_state),
    .q    (st_s)
  );

  assign hb    = st_s[HB];
  assign empty = st_s[EMPTY];

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    tmr_n       = tmr;
    ph_n        = ph;
    wcnt_n      = wcnt;
    capture     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = RST;
          tmr_n   = '0;
        end
      end
      RST: begin
        if (tmr == TW'(RST_CYCLES - 1)) state_n = ARM;
        else                            tmr_n   = tmr + 1'b1;
      end
      ARM: begin
        if (sync_p || sync_pend) begin
          state_n = COLLECT;
          tmr_n   = '0;
        end
      end
      COLLECT: begin
        if (hb && !empty) begin
          state_n = DRAIN;
          ph_n    = '0;
          wcnt_n  = '0;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          state_n     = RST;
          tmr_n       = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      DRAIN: begin
        // One read: strobe at ph 0, capture at RD_LAT, write at RD_LAT+1,
        // re-sample empty at RD_LAT+3 before deciding on the next strobe.
        ph_n = ph + 1'b1;
        if (ph == PW'(RD_LAT))     capture = 1'b1;
        if (ph == PW'(RD_LAT + 1)) wcnt_n  = wcnt + 1'b1;
        if (ph == PW'(RD_LAT + 3)) begin
          ph_n = '0;
          if (empty || wcnt == CW'(BLOCK_LEN)) state_n = DONE;
        end
      end
      DONE:    state_n = ARM;
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  // A sync landing on the transition into ARM is held one cycle so ARM sees it.
  assign arm_entry   = (state_n == ARM) && (state != ARM);
  assign sync_pend_n = arm_entry && sync_p;
  assign set_overrun = sync_p && (state != ARM) && !arm_entry;

  // NOTE: reset is synchronous and also clears the captured data word, so the
  // buffer port shows a defined value rather than stale data after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      tmr         <= '0;
      ph          <= '0;
      wcnt        <= '0;
      sync_pend   <= 1'b0;
      mtd_wdata   <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      tmr         <= tmr_n;
      ph          <= ph_n;
      wcnt        <= wcnt_n;
      sync_pend   <= sync_pend_n;
      if (capture) mtd_wdata <= extern_mtd_data;
      err_timeout <= set_timeout | (err_timeout & ~err_clr);
      err_overrun <= set_overrun | (err_overrun & ~err_clr);
    end
  end

  assign extern_mtd_rst = (state == IDLE) || (state == RST);
  assign extern_mtd_en  = (state == DRAIN) && (ph == '0);
  assign mtd_wen        = (state == DRAIN) && (ph == PW'(RD_LAT + 1));
  assign mtd_done       = (state == DONE);
  assign busy           = (state != IDLE) && (state != ARM);
  assign mtd_waddr      = wcnt[AW-1:0];

endmodule

// File: tb/tb_mtd_ctrl.sv
// Self-checking bench for mtd_ctrl: a behavioural MTD engine model plus a
// write-port scoreboard, with one task per scenario.
module tb_mtd_ctrl;

  localparam int RST_CYCLES = 16;
  localparam int RD_LAT     = 2;
  localparam int BLOCK_LEN  = 8;
  localparam int TIMEOUT    = 100;
  localparam int AW         = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          synclk = 1'b0;
  logic          err_clr = 1'b0;
  logic [1:0]    extern_mtd_state;
  logic [15:0]   extern_mtd_data;
  logic          extern_mtd_en;
  logic          extern_mtd_rst;
  logic          mtd_wen;
  logic [15:0]   mtd_wdata;
  logic [AW-1:0] mtd_waddr;
  logic          mtd_done;
  logic          err_timeout;
  logic          err_overrun;
  logic          busy;

  mtd_ctrl #(
    .RST_CYCLES(RST_CYCLES),
    .RD_LAT    (RD_LAT),
    .BLOCK_LEN (BLOCK_LEN),
    .TIMEOUT   (TIMEOUT),
    .AW        (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .synclk          (synclk),
    .err_clr         (err_clr),
    .extern_mtd_state(extern_mtd_state),
    .extern_mtd_data (extern_mtd_data),
    .extern_mtd_en   (extern_mtd_en),
    .extern_mtd_rst  (extern_mtd_rst),
    .mtd_wen         (mtd_wen),
    .mtd_wdata       (mtd_wdata),
    .mtd_waddr       (mtd_waddr),
    .mtd_done        (mtd_done),
    .err_timeout     (err_timeout),
    .err_overrun     (err_overrun),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] w;
  } pend_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          wen_cnt = 0;
  int          done_cnt = 0;
  int          en_cyc[$];
  exp_t        exp_q[$];
  exp_t        e;
  pend_t       pend_q[$];
  logic [15:0] eng_q[$];
  logic [15:0] eng_w;
  logic        eng_hb = 1'b0;
  logic        eng_empty = 1'b1;
  logic [15:0] eng_data = 16'hBAD0;

  assign extern_mtd_state = {eng_hb, eng_empty};
  assign extern_mtd_data  = eng_data;

  // Engine model: a word popped on a strobe is driven only in the cycle that
  // ends RD_LAT edges after the strobe, garbage otherwise.
  always @(negedge clk) begin
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      eng_data = pend_q[0].w;
      void'(pend_q.pop_front());
    end else begin
      eng_data = 16'hBAD0;
    end
    if (extern_mtd_rst) begin
      eng_q.delete();
      pend_q.delete();
    end else if (extern_mtd_en) begin
      eng_w = (eng_q.size() > 0) ? eng_q.pop_front() : 16'hDEAD;
      pend_q.push_back('{cyc + RD_LAT, eng_w});
      en_cnt++;
      en_cyc.push_back(cyc);
    end
    eng_empty = (eng_q.size() == 0);
    if (mtd_done) done_cnt++;
    if (mtd_wen) begin
      wen_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wen_unexpected: got addr %0d data %h, expected no write",
                 mtd_waddr, mtd_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mtd_waddr !== e.addr || mtd_wdata !== e.data) begin
          miscompares++;
          $display("FAIL wen_word: got addr %0d data %h, expected addr %0d data %h",
                   mtd_waddr, mtd_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    en_cnt = 0;
    wen_cnt = 0;
    done_cnt = 0;
    en_cyc.delete();
  endtask

  task automatic send_sync();
    synclk = 1'b1;
    repeat (3) tick();
    synclk = 1'b0;
  endtask

  // Loads a block into the engine and queues the words the DUT should write.
  task automatic load_block(input logic [15:0] base, input int n, input int n_exp);
    for (int i = 0; i < n; i++) begin
      eng_q.push_back(base + 16'(i));
      if (i < n_exp) exp_q.push_back('{AW'(i), base + 16'(i)});
    end
    eng_hb = 1'b1;
  endtask

  // Counts cycles spent in the engine-reset state; returns at the first cycle after.
  task automatic count_rst(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy && extern_mtd_rst) n++;
      else if (n > 0) break;
      tick();
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    vectors++;
    if (extern_mtd_rst !== 1'b1 || extern_mtd_en !== 1'b0 || mtd_wen !== 1'b0 ||
        mtd_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rst=%b en=%b wen=%b done=%b busy=%b, expected 1 0 0 0 0",
               extern_mtd_rst, extern_mtd_en, mtd_wen, mtd_done, busy);
    end
    vectors++;
    if (mtd_wdata !== 16'h0 || mtd_waddr !== '0 || err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: got wdata=%h waddr=%0d et=%b eo=%b, expected all zero",
               mtd_wdata, mtd_waddr, err_timeout, err_overrun);
    end
  endtask

  task automatic test_rst_seq();
    int n;
    reset = 1'b1;
    enable = 1'b1;
    count_rst(n);
    vectors++;
    if (n !== RST_CYCLES) begin
      miscompares++;
      $display("FAIL rst_len: got %0d cycles, expected %0d", n, RST_CYCLES);
    end
    vectors++;
    if (extern_mtd_rst !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL arm_idle: got rst=%b busy=%b, expected 0 0", extern_mtd_rst, busy);
    end
  endtask

  task automatic test_drain();
    int gap;
    clear_counts();
    load_block(16'h1111, 5, 0);
    eng_q.delete();
    for (int i = 1; i <= 5; i++) begin
      eng_q.push_back(16'h1111 * 16'(i));
      exp_q.push_back('{AW'(i - 1), 16'h1111 * 16'(i)});
    end
    send_sync();
    wait_done(1);
    repeat (20) tick();
    eng_hb = 1'b0;
    vectors++;
    if (done_cnt !== 1 || wen_cnt !== 5 || en_cnt !== 5) begin
      miscompares++;
      $display("FAIL drain_counts: got done=%0d wen=%0d en=%0d, expected 1 5 5",
               done_cnt, wen_cnt, en_cnt);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL drain_missing: got %0d words unwritten, expected 0", exp_q.size());
    end
    gap = (en_cyc.size() >= 2) ? en_cyc[1] - en_cyc[0] : -1;
    vectors++;
    if (gap !== RD_LAT + 4) begin
      miscompares++;
      $display("FAIL drain_rate: got strobe gap %0d, expected %0d", gap, RD_LAT + 4);
    end
    vectors++;
    if (busy !== 1'b0 || extern_mtd_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_back_to_arm: got busy=%b rst=%b, expected 0 0", busy, extern_mtd_rst);
    end
  endtask

  task automatic test_timeout();
    int t0, d, n;
    clear_counts();
    eng_hb = 1'b0;
    t0 = cyc;
    send_sync();
    for (int i = 0; i < 300 && err_timeout !== 1'b1; i++) tick();
    d = cyc - t0;
    vectors++;
    if (err_timeout !== 1'b1 || d < TIMEOUT + 1 || d > TIMEOUT + 6) begin
      miscompares++;
      $display("FAIL timeout_time: got flag=%b after %0d cycles, expected 1 after %0d..%0d",
               err_timeout, d, TIMEOUT + 1, TIMEOUT + 6);
    end
    count_rst(n);
    vectors++;
    if (n !== RST_CYCLES || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_rst: got %0d reset cycles busy=%b, expected %0d busy=0",
               n, busy, RST_CYCLES);
    end
    repeat (5) tick();
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got %b, expected 1", err_timeout);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    vectors++;
    if (err_timeout !== 1'b0 || done_cnt !== 0 || wen_cnt !== 0) begin
      miscompares++;
      $display("FAIL timeout_clear: got flag=%b done=%0d wen=%0d, expected 0 0 0",
               err_timeout, done_cnt, wen_cnt);
    end
  endtask

  task automatic test_block_len();
    clear_counts();
    load_block(16'hA000, 12, BLOCK_LEN);
    send_sync();
    wait_done(1);
    repeat (10) tick();
    vectors++;
    if (wen_cnt !== BLOCK_LEN || en_cnt !== BLOCK_LEN || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL blocklen_counts: got wen=%0d en=%0d done=%0d, expected %0d %0d 1",
               wen_cnt, en_cnt, done_cnt, BLOCK_LEN, BLOCK_LEN);
    end
    vectors++;
    if (exp_q.size() !== 0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL blocklen_end: got left=%0d busy=%b et=%b, expected 0 0 0",
               exp_q.size(), busy, err_timeout);
    end
    eng_q.delete();
    eng_hb = 1'b0;
  endtask

  task automatic test_overrun();
    clear_counts();
    load_block(16'hC000, 5, 5);
    send_sync();
    for (int i = 0; i < 200 && wen_cnt < 1; i++) tick();
    send_sync();
    wait_done(1);
    repeat (5) tick();
    vectors++;
    if (err_overrun !== 1'b1 || wen_cnt !== 5 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL overrun_drain: got eo=%b wen=%0d done=%0d, expected 1 5 1",
               err_overrun, wen_cnt, done_cnt);
    end
    load_block(16'h3300, 2, 2);
    repeat (40) tick();
    vectors++;
    if (wen_cnt !== 5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_no_resync: got wen=%0d busy=%b, expected 5 0", wen_cnt, busy);
    end
    send_sync();
    wait_done(2);
    repeat (5) tick();
    eng_hb = 1'b0;
    vectors++;
    if (wen_cnt !== 7 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL overrun_next_block: got wen=%0d left=%0d, expected 7 0", wen_cnt, exp_q.size());
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (err_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %b, expected 0", err_overrun);
    end
  endtask

  task automatic test_abort();
    int n;
    clear_counts();
    load_block(16'hE000, 4, 1);
    send_sync();
    for (int i = 0; i < 200 && en_cnt < 2; i++) tick();
    tick();
    enable = 1'b0;
    tick();
    vectors++;
    if (extern_mtd_rst !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got rst=%b busy=%b, expected 1 0", extern_mtd_rst, busy);
    end
    repeat (10) tick();
    eng_hb = 1'b0;
    vectors++;
    if (wen_cnt !== 1 || en_cnt !== 2 || done_cnt !== 0 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL abort_inflight: got wen=%0d en=%0d done=%0d left=%0d, expected 1 2 0 0",
               wen_cnt, en_cnt, done_cnt, exp_q.size());
    end

    clear_counts();
    enable = 1'b1;
    count_rst(n);
    vectors++;
    if (n !== RST_CYCLES) begin
      miscompares++;
      $display("FAIL rearm_rst_len: got %0d, expected %0d", n, RST_CYCLES);
    end
    load_block(16'h7000, 3, 1);
    send_sync();
    for (int i = 0; i < 200 && en_cnt < 2; i++) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (extern_mtd_rst !== 1'b1 || extern_mtd_en !== 1'b0 || mtd_wen !== 1'b0 ||
        mtd_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got rst=%b en=%b wen=%b done=%b busy=%b, expected 1 0 0 0 0",
               extern_mtd_rst, extern_mtd_en, mtd_wen, mtd_done, busy);
    end
    vectors++;
    if (mtd_waddr !== '0 || mtd_wdata !== 16'h0 || err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_data: got waddr=%0d wdata=%h et=%b eo=%b, expected all zero",
               mtd_waddr, mtd_wdata, err_timeout, err_overrun);
    end
    repeat (2) tick();
    reset = 1'b1;
    eng_hb = 1'b0;
    repeat (30) tick();
    vectors++;
    if (wen_cnt !== 1 || done_cnt !== 0 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got wen=%0d done=%0d left=%0d, expected 1 0 0",
               wen_cnt, done_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rst_seq();
    test_drain();
    test_timeout();
    test_block_len();
    test_overrun();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
